// File: rtl/bk8_serial_sub_if.sv
// Valid/ready operand and result stream bundle for bk8_serial_sub.
// master drives operands and consumes results; slave is the subtractor side.
interface bk8_serial_sub_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_diff;
   logic       out_last;
   logic       out_borrow;
   logic       out_zero;
   logic       out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_diff, out_last, out_borrow, out_zero, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_diff, out_last, out_borrow, out_zero, out_ovf
   );
endinterface

// File: rtl/bk8_serial_sub.sv
// Byte-serial multi-byte subtractor (A - B, LSB first) on an 8-bit Brent-Kung slice.
// Optional signed-overflow flag enabled by defining BKSUB_OVF_EN.
module bk8_serial_sub (
   input  logic              clk,
   input  logic              rst_n,
   bk8_serial_sub_if.slave   bus
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t     state_q, state_d;
   logic       c_q, c_d;
   logic       z_q, z_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_diff_q, out_diff_d;
   logic       out_last_q, out_last_d;
   logic       out_borrow_q, out_borrow_d;
   logic       out_zero_q, out_zero_d;

   logic       in_ready;
   logic       accept;
   logic       cin;
   logic       zin;
   logic       diff_zero;
   logic       c_next;
   logic [7:0] diff;
   logic [8:0] cy;
   logic [7:0] g, p, g1, p1, g2, p2, g3, p3, gf, pf;

   // ---------------- Brent-Kung prefix slice: a + ~b + cin ----------------
   always_comb begin
      g  = bus.in_a & ~bus.in_b;
      p  = bus.in_a ^ ~bus.in_b;
      g1 = g;
      p1 = p;
      for (int unsigned i = 1; i < 8; i += 2) begin
         g1[i] = g[i] | (p[i] & g[i-1]);
         p1[i] = p[i] & p[i-1];
      end
      g2    = g1;
      p2    = p1;
      g2[3] = g1[3] | (p1[3] & g1[1]);
      p2[3] = p1[3] & p1[1];
      g2[7] = g1[7] | (p1[7] & g1[5]);
      p2[7] = p1[7] & p1[5];
      g3    = g2;
      p3    = p2;
      g3[7] = g2[7] | (p2[7] & g2[3]);
      p3[7] = p2[7] & p2[3];
      // Reverse tree fills the remaining group spans from bit 0
      gf    = g3;
      pf    = p3;
      gf[5] = g3[5] | (p3[5] & g3[3]);
      pf[5] = p3[5] & p3[3];
      gf[2] = g3[2] | (p3[2] & g3[1]);
      pf[2] = p3[2] & p3[1];
      gf[4] = g3[4] | (p3[4] & g3[3]);
      pf[4] = p3[4] & p3[3];
      gf[6] = g3[6] | (p3[6] & gf[5]);
      pf[6] = p3[6] & pf[5];
      cy[0] = cin;
      for (int unsigned i = 0; i < 8; i++) begin
         cy[i+1] = gf[i] | (pf[i] & cin);
      end
      diff   = p ^ cy[7:0];
      c_next = cy[8];
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = bus.in_last ? IDLE : ACCUM;
      end
   end

   // ---------------- FSM: outputs / handshake ----------------
   always_comb begin
      in_ready  = ~out_valid_q | bus.out_ready;
      accept    = bus.in_valid & in_ready;
      cin       = (state_q == IDLE) ? 1'b1 : c_q;
      zin       = (state_q == IDLE) ? 1'b1 : z_q;
      diff_zero = (diff == '0);
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      c_d          = c_q;
      z_d          = z_q;
      out_valid_d  = out_valid_q;
      out_diff_d   = out_diff_q;
      out_last_d   = out_last_q;
      out_borrow_d = out_borrow_q;
      out_zero_d   = out_zero_q;
      if (accept) begin
         c_d          = bus.in_last ? 1'b1 : c_next;
         z_d          = bus.in_last ? 1'b1 : (zin & diff_zero);
         out_valid_d  = 1'b1;
         out_diff_d   = diff;
         out_last_d   = bus.in_last;
         out_borrow_d = bus.in_last & ~c_next;
         out_zero_d   = bus.in_last & zin & diff_zero;
      end else if (bus.out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q          <= 1'b1;
         z_q          <= 1'b1;
         out_valid_q  <= 1'b0;
         out_diff_q   <= '0;
         out_last_q   <= 1'b0;
         out_borrow_q <= 1'b0;
         out_zero_q   <= 1'b0;
      end else begin
         c_q          <= c_d;
         z_q          <= z_d;
         out_valid_q  <= out_valid_d;
         out_diff_q   <= out_diff_d;
         out_last_q   <= out_last_d;
         out_borrow_q <= out_borrow_d;
         out_zero_q   <= out_zero_d;
      end
   end

`ifdef BKSUB_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (accept) begin
         ovf_d = bus.in_last & (bus.in_a[7] != bus.in_b[7]) & (diff[7] != bus.in_a[7]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign bus.out_ovf = ovf_q;
`else
   assign bus.out_ovf = 1'b0;
`endif

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_diff   = out_diff_q;
   assign bus.out_last   = out_last_q;
   assign bus.out_borrow = out_borrow_q;
   assign bus.out_zero   = out_zero_q;

endmodule

// File: doc/bk8_serial_sub.md
# bk8_serial_sub

Sequential multi-byte subtractor built around the 8-bit Brent-Kung prefix slice. It computes A − B for operands of arbitrary byte length, taking one byte pair per beat, least-significant byte first. The borrow chains across beats in a registered carry. It sits downstream of operand buffers and upstream of the result/flag consumer, using valid/ready handshakes on both sides.

## Interface
- No parameters; the slice width is fixed at 8 bits.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the input beat is valid.
- `in_ready`  out  1  the block accepts a beat; a beat transfers when `in_valid & in_ready`.
- `in_a`  in  8  minuend byte.
- `in_b`  in  8  subtrahend byte.
- `in_last`  in  1  the beat is the most-significant byte of the operand.
- `out_valid`  out  1  the output beat is valid.
- `out_ready`  in  1  the consumer accepts a beat; a beat transfers when `out_valid & out_ready`.
- `out_diff`  out  8  difference byte.
- `out_last`  out  1  the beat is the most-significant result byte.
- `out_borrow`  out  1  final unsigned borrow (A < B); meaningful only when `out_last` is 1, otherwise 0.
- `out_zero`  out  1  the whole multi-byte result is zero; meaningful only when `out_last` is 1, otherwise 0.
- `out_ovf`  out  1  signed overflow; meaningful only when `out_last` is 1 (see Configuration).

## Operation
- Each beat computes `{c_next, out_diff} = in_a + ~in_b + c` using the Brent-Kung prefix network (g/p generate, prefix tree, sum XOR).
- Carry register `c`:
  - Reset value 1.
  - After an accepted beat with `in_last` = 1, `c` returns to 1.
  - After any other accepted beat, `c` takes `c_next`.
- Zero accumulator `z`:
  - Reset value 1.
  - On each accepted beat, `z` becomes `z & (diff == 0)`; it is reloaded to 1 after a last beat.
  - On the last beat, `out_zero` = `z & (diff == 0)`.
- `out_borrow` = `~c_next` on the last beat.
- State machine, two states:
  - IDLE: awaiting the first byte. Reset state.
  - ACCUM: mid-operand.
  - IDLE → ACCUM on an accepted beat with `in_last` = 0.
  - ACCUM → IDLE on an accepted beat with `in_last` = 1.
  - An accepted beat with `in_last` = 1 while in IDLE (single-byte operand) stays in IDLE.
- The first beat in IDLE always uses carry 1, whatever the previous history.
- The output register holds one beat: `in_ready = ~out_valid | out_ready`.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented on the outputs from edge N onward, until it is consumed.
- Throughput is one beat per cycle while `out_ready` = 1.
- Backpressure: when `out_valid` = 1 and `out_ready` = 0, all outputs hold stable and `in_ready` = 0. No beat is lost or duplicated.
- Simultaneous consume and accept in the same cycle: the output register loads the new beat, and `out_valid` stays 1.
- Reset values:
  - All outputs 0 (`out_valid`, `out_diff`, `out_last`, `out_borrow`, `out_zero`, `out_ovf`).
  - `in_ready` = 1 after reset.
  - State IDLE, `c` = 1, `z` = 1.
- Reset asserted mid-operand: the partial operand is discarded, and the next accepted beat is treated as a first byte.
- `in_a`, `in_b` and `in_last` are ignored when `in_valid` = 0.

## Configuration
- `BKSUB_OVF_EN` defined:
  - `out_ovf` = `(a7 != b7) & (d7 != a7)` on the last beat, where a7, b7 and d7 are the top bits of the last beat's `in_a`, `in_b` and `out_diff`.
  - Otherwise `out_ovf` = 0.
- `BKSUB_OVF_EN` undefined: `out_ovf` is tied to 0, and the overflow logic and its register bit are absent.

## Test plan
- Single beat, a=0x05, b=0x03, last=1 → diff=0x02, borrow=0, zero=0, out_last=1, one cycle after acceptance.
- Single beat, a=0x03, b=0x05, last=1 → diff=0xFE, borrow=1, zero=0.
- Two beats, 0x0100 − 0x0001: beat (a=0x00, b=0x01), then beat (a=0x01, b=0x00, last) → diffs 0xFF then 0x00, borrow=0, zero=0.
- Three beats, equal operands 0x123456 − 0x123456 → diffs 0x00, 0x00, 0x00, zero=1 on the last beat, borrow=0. Hold `out_ready`=0 for 3 cycles mid-stream → outputs are stable, `in_ready`=0, and no beat is lost.
- Assert `rst_n` low after the first beat of a two-beat operand, then send a single beat a=0x00, b=0x00, last=1 → diff=0x00, borrow=0, zero=1 (no stale carry). All outputs read 0 during reset.
- With `BKSUB_OVF_EN` defined: single beat, 0x80 − 0x01 → diff=0x7F, ovf=1, borrow=0. With the macro undefined, the same stimulus → ovf=0.
